bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum cycles an owner keeps the bus while another requester is pending; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  bus requests, held high while wanted: bit0 R0, bit1 ALU, bit2 PC, bit3 switch input.
REQ-005 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-006 nr0_bus  output  1  active-low R0 bus-drive enable, equals ~gnt[0].
REQ-007 nalu_bus  output  1  active-low ALU bus-drive enable, equals ~gnt[1].
REQ-008 npc_bus  output  1  active-low PC bus-drive enable, equals ~gnt[2].
REQ-009 nsw_bus  output  1  active-low switch bus-drive enable, equals ~gnt[3].
REQ-010 gnt_id  output  2  index of current owner; holds last owner index when gnt is zero.
REQ-011 busy  output  1  high when state is OWN.

Function
REQ-012 The block SHALL implement three states: IDLE (no owner), OWN (one owner drives bus), GAP (one dead cycle, no driver).
REQ-013 At most one of nr0_bus/nalu_bus/npc_bus/nsw_bus SHALL be low in any cycle; in IDLE and GAP all four SHALL be high.
REQ-014 Arbitration SHALL be round-robin: a 2-bit pointer names the highest-priority requester; search order is pointer, pointer+1, ... modulo 4.
REQ-015 On granting requester i, the pointer SHALL become (i+1) mod 4 on the same edge.
REQ-016 IDLE: if any req bit is high at an edge, the winner SHALL own the bus from the next cycle (state OWN, 1-cycle latency); otherwise stay IDLE.
REQ-017 OWN: if the owner's req bit is low at an edge, the next state SHALL be GAP.
REQ-018 OWN: a hold counter SHALL clear on entry and increment each OWN cycle, saturating at MAX_HOLD-1.
REQ-019 OWN: if hold counter equals MAX_HOLD-1, owner req still high and any other req bit high, the owner SHALL be preempted: next state GAP.
REQ-020 OWN with no other requester pending SHALL keep ownership indefinitely; the counter stays saturated and preemption occurs on the first edge another request is seen.
REQ-021 GAP: arbitration SHALL run on the GAP cycle's req; winner owns the bus next cycle (OWN); if no req, next state IDLE.
REQ-022 A preempted owner whose req is still high SHALL compete normally in GAP; with the pointer advanced it loses to any other pending requester.
REQ-023 A request that drops before its grant SHALL never be granted; no request is latched.
REQ-024 Owner-drop and preemption on the same edge SHALL produce a single GAP cycle.
REQ-025 Handover latency from owner req falling (sampled edge N) to new owner's enable low SHALL be exactly 2 cycles (GAP at N+1, OWN at N+2).

Reset
REQ-026 While reset is high at an edge: state IDLE, gnt=0000, all four n*_bus=1, gnt_id=00, busy=0, pointer=00, hold counter=0; reset overrides all other inputs.
REQ-027 Reset asserted during OWN SHALL release the bus on the following cycle with no GAP cycle and no grant carried over.

Verification
REQ-028 Reset, then req=0101 for one edge -> next cycle gnt=0001, nr0_bus=0, others 1, gnt_id=00, busy=1.
REQ-029 Owner R0, drop req[0] with req=0110 pending -> 1 GAP cycle all n*_bus=1, then gnt=0010 (ALU); after ALU drops -> GAP then gnt=0100 (PC).
REQ-030 MAX_HOLD=4, req=0011 constant from IDLE -> R0 owns 4 cycles, GAP, ALU owns 4 cycles, GAP, R0 again; never two enables low together.
REQ-031 Single req=1000 held 40 cycles -> nsw_bus low continuously after 1-cycle latency; no GAP; then req[2] raised -> GAP next edge, PC owns after.
REQ-032 reset pulsed for one cycle while ALU owns -> next cycle gnt=0000, pointer=00; with req=1111 afterwards -> R0 granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin owner selection for a shared bus with four drivers
//   (R0, ALU, PC, switch input). An owner keeps the bus while it requests,
//   up to MAX_HOLD cycles when someone else is waiting. Every change of owner
//   passes through a single dead GAP cycle so two drivers never overlap.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   req[3:0]     in   requests, level-held: 0=R0 1=ALU 2=PC 3=switch
//   gnt[3:0]     out  registered one-hot grant, zero when nobody owns the bus
//   nr0_bus      out  active-low R0 drive enable     (~gnt[0])
//   nalu_bus     out  active-low ALU drive enable    (~gnt[1])
//   npc_bus      out  active-low PC drive enable     (~gnt[2])
//   nsw_bus      out  active-low switch drive enable (~gnt[3])
//   gnt_id[1:0]  out  index of current/last owner
//   busy         out  high while in OWN
//   o_dbg_state  out  raw FSM state (0 IDLE, 1 OWN, 2 GAP)
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       nr0_bus,
    output logic       nalu_bus,
    output logic       npc_bus,
    output logic       nsw_bus,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic [1:0] r_ptr;
    logic [7:0] r_hold;

    logic       w_win_valid;
    logic [1:0] w_win_idx;
    logic [1:0] w_cand;
    logic [3:0] w_win_onehot;
    logic       w_own_req;
    logic       w_others;
    logic       w_release;

    // Round-robin search. Walk from the farthest offset back to the pointer
    // so the last hit written is the one closest to the pointer.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = 2'd0;
        w_cand      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (req[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    assign w_win_onehot = 4'b0001 << w_win_idx;
    assign w_own_req    = req[r_gnt_id];
    assign w_others     = |(req & ~r_gnt);
    // Owner drop and hold expiry both land in the same single GAP cycle.
    assign w_release    = !w_own_req || ((r_hold == HOLD_LAST) && w_others);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_ptr    <= 2'd0;
            r_hold   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_win_valid) begin
                        r_state  <= S_OWN;
                        r_gnt    <= w_win_onehot;
                        r_gnt_id <= w_win_idx;
                        r_ptr    <= w_win_idx + 2'd1;
                        r_hold   <= 8'd0;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= 4'b0000;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        r_state <= S_GAP;
                        r_gnt   <= 4'b0000;
                    end else if (r_hold != HOLD_LAST) begin
                        // Saturates so a lone owner keeps the bus indefinitely
                        // yet yields on the first edge a rival shows up.
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign nr0_bus     = ~r_gnt[0];
    assign nalu_bus    = ~r_gnt[1];
    assign npc_bus     = ~r_gnt[2];
    assign nsw_bus     = ~r_gnt[3];
    assign gnt_id      = r_gnt_id;
    assign busy        = (r_state == S_OWN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int W = 11; // {gnt, gnt_id, busy, n_bus[3:0]}

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       nr0_bus, nalu_bus, npc_bus, nsw_bus;
  logic [1:0] gnt_id;
  logic       busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .nr0_bus(nr0_bus),
    .nalu_bus(nalu_bus),
    .npc_bus(npc_bus),
    .nsw_bus(nsw_bus),
    .gnt_id(gnt_id),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: 0 IDLE, 1 OWN, 2 GAP
  int m_state = 0;
  int m_ptr = 0;
  int m_owner = 0;
  int m_hold = 0;

  task automatic model_step(input logic [3:0] r, input logic rst);
    int pick;
    pick = -1;
    if (rst) begin
      m_state = 0; m_ptr = 0; m_owner = 0; m_hold = 0;
    end else if (m_state == 1) begin
      if (r[m_owner] == 1'b0)
        m_state = 2;
      else if (m_hold == MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000)
        m_state = 2;
      else if (m_hold < MAX_HOLD - 1)
        m_hold = m_hold + 1;
    end else begin
      for (int off = 0; off < 4; off++) begin
        if (pick < 0 && r[(m_ptr + off) % 4]) pick = (m_ptr + off) % 4;
      end
      if (pick >= 0) begin
        m_state = 1; m_owner = pick; m_ptr = (pick + 1) % 4; m_hold = 0;
      end else begin
        m_state = 0;
      end
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [3:0] g;
    g = (m_state == 1) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_owner), (m_state == 1), ~g};
  endfunction

  // driver: one clock per call, push expectation, compare after the edge
  task automatic step(input logic [3:0] r, input logic rst);
    logic [W-1:0] e;
    req = r;
    reset = rst;
    model_step(r, rst);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("outputs", {gnt, gnt_id, busy, nsw_bus, npc_bus, nalu_bus, nr0_bus}, e);
    end
    check_eq("one_driver", ($countones(~{nsw_bus, npc_bus, nalu_bus, nr0_bus}) <= 1), 1);
  endtask

  logic [3:0] seq_exp[11];
  int sw_low;

  initial begin
    // reset state
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check_eq("rst_gnt", gnt, 4'b0000);
    check_eq("rst_nbus", {nsw_bus, npc_bus, nalu_bus, nr0_bus}, 4'b1111);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_id", gnt_id, 2'd0);

    // first grant, 1-cycle latency
    step(4'b0101, 1'b0);
    check_eq("first_gnt", gnt, 4'b0001);
    check_eq("first_nr0", nr0_bus, 1'b0);
    check_eq("first_busy", busy, 1'b1);
    // owner drop -> gap -> ALU -> gap -> PC
    step(4'b0110, 1'b0);
    check_eq("gap1_nbus", {nsw_bus, npc_bus, nalu_bus, nr0_bus}, 4'b1111);
    step(4'b0110, 1'b0);
    check_eq("alu_gnt", gnt, 4'b0010);
    step(4'b0100, 1'b0);
    check_eq("gap2_gnt", gnt, 4'b0000);
    step(4'b0100, 1'b0);
    check_eq("pc_gnt", gnt, 4'b0100);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check_eq("idle_state", dbg_state, 2'd0);

    // hold limit with two steady requesters
    seq_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    step(4'b0000, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(4'b0011, 1'b0);
      check_eq($sformatf("hold_seq%0d", i), gnt, seq_exp[i]);
    end

    // lone switch owner never yields, then PC arrives
    step(4'b0000, 1'b1);
    sw_low = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b1000, 1'b0);
      if (nsw_bus == 1'b0) sw_low++;
    end
    check_eq("sw_low_cycles", sw_low, 40);
    step(4'b1100, 1'b0);
    check_eq("sw_preempt_gap", gnt, 4'b0000);
    step(4'b1100, 1'b0);
    check_eq("pc_after_sw", gnt, 4'b0100);

    // reset while ALU owns
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    check_eq("alu_own", gnt, 4'b0010);
    step(4'b0010, 1'b1);
    check_eq("rst_release", gnt, 4'b0000);
    step(4'b1111, 1'b0);
    check_eq("ptr_cleared", gnt, 4'b0001);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
